// File: rtl/mp_add_ctrl_pkg.sv
// Shared definitions for the slice-serial multi-precision adder/subtractor:
// default geometry and the controller state encoding.
package mp_add_ctrl_pkg;

   localparam int WIDTH_DEF  = 256;
   localparam int CELL_W_DEF = 16;
   localparam int N_DEF      = WIDTH_DEF / CELL_W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mp_add_ctrl_cla_cell.sv
// CLA_cell: combinational CELL_W-bit carry-lookahead adder slice built on a
// parallel-prefix (Kogge-Stone) generate/propagate tree.
module CLA_cell
   import mp_add_ctrl_pkg::*;
#(
   parameter int CELL_W = CELL_W_DEF
) (
   input  logic [CELL_W-1:0] a,
   input  logic [CELL_W-1:0] b,
   input  logic              cin,
   output logic              cout,
   output logic [CELL_W-1:0] s
);

   localparam int STAGES = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam logic [CELL_W-1:0] ONES = '1;

   logic [CELL_W-1:0] p_s;
   logic [CELL_W-1:0] gg_s;
   logic [CELL_W-1:0] pp_s;
   logic [CELL_W:0]   c_s;

   // Prefix tree: after the last stage gg_s[i]/pp_s[i] span bits i..0, so every
   // carry comes straight from cin without rippling through lower bits.
   always_comb begin
      p_s  = a ^ b;
      gg_s = a & b;
      pp_s = a ^ b;
      for (int k = 0; k < STAGES; k++) begin
         gg_s = gg_s | (pp_s & (gg_s << (1 << k)));
         pp_s = pp_s & ((pp_s << (1 << k)) | ~(ONES << (1 << k)));
      end
      c_s = {gg_s | (pp_s & {CELL_W{cin}}), cin};
   end

   assign s    = p_s ^ c_s[CELL_W-1:0];
   assign cout = c_s[CELL_W];

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision add/subtract controller: walks a WIDTH-bit operation through
// one shared CLA_cell, one CELL_W slice per cycle, least significant slice first.
module mp_add_ctrl
   import mp_add_ctrl_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int CELL_W = CELL_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int N_SL  = WIDTH / CELL_W;
   localparam int IDX_W = (N_SL > 1) ? $clog2(N_SL) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SL - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

   state_t            state_r;
   state_t            next_state_s;
   logic              accept_s;
   logic              last_s;

   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [WIDTH-1:0]  s_r;
   logic              op_r;
   logic              carry_r;
   logic              cout_r;
   logic              busy_r;
   logic              done_r;
   logic [IDX_W-1:0]  idx_r;

   logic [CELL_W-1:0] b_slice_s;
   logic [CELL_W-1:0] cell_a_s;
   logic [CELL_W-1:0] cell_b_s;
   logic [CELL_W-1:0] cell_s_s;
   logic              cell_cout_s;

   // Next-state logic; start is only looked at when no operation is running.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      last_s       = (idx_r == IDX_LAST);
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               accept_s     = 1'b1;
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State register with busy/done registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s == ST_RUN);
         done_r  <= (next_state_s == ST_DONE);
      end
   end

   // Subtraction is a + ~b + 1: the slice of b is inverted and the carry seeded with op.
   always_comb begin
      cell_a_s  = a_r[idx_r*CELL_W +: CELL_W];
      b_slice_s = b_r[idx_r*CELL_W +: CELL_W];
      if (op_r) begin
         cell_b_s = ~b_slice_s;
      end else begin
         cell_b_s = b_slice_s;
      end
   end

   CLA_cell #(
      .CELL_W (CELL_W)
   ) u_cell (
      .a    (cell_a_s),
      .b    (cell_b_s),
      .cin  (carry_r),
      .cout (cell_cout_s),
      .s    (cell_s_s)
   );

   // Operand capture and slice-by-slice result accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         s_r     <= '0;
         op_r    <= 1'b0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         idx_r   <= IDX_ZERO;
      end else if (accept_s) begin
         a_r     <= a;
         b_r     <= b;
         op_r    <= op;
         carry_r <= op;
         idx_r   <= IDX_ZERO;
      end else if (state_r == ST_RUN) begin
         s_r[idx_r*CELL_W +: CELL_W] <= cell_s_s;
         carry_r                     <= cell_cout_s;
         idx_r                       <= idx_r + IDX_ONE;
         if (last_s) begin
            cout_r <= cell_cout_s;
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign s    = s_r;
   assign cout = cout_r;

endmodule
